// File: rtl/rgmii_pkg.sv
// Shared RGMII definitions: transmit state encoding, line byte constants and
// a saturating counter helper, used by both transmit and receive sides.
package rgmii_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    DRAIN    = 3'd4,
    IFG      = 3'd5
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rgmii_ddr_output_buffer.sv
// Behavioural DDR output register pair; a vendor ODDR primitive replaces this
// for synthesis. High-phase values show while clock is high, low-phase while low.
module rgmii_ddr_output_buffer #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_high,
  input  logic [DATA_WIDTH-1:0] data_low,
  input  logic                  ctl_high,
  input  logic                  ctl_low,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ctl_out
);

  logic [DATA_WIDTH-1:0] data_high_q;
  logic [DATA_WIDTH-1:0] data_low_hold;
  logic [DATA_WIDTH-1:0] data_low_q;
  logic                  ctl_high_q;
  logic                  ctl_low_hold;
  logic                  ctl_low_q;

  // Rising edge: launch the high phase and hold the low half for the negedge
  always_ff @(posedge clock) begin
    if (reset) begin
      data_high_q   <= '0;
      data_low_hold <= '0;
      ctl_high_q    <= 1'b0;
      ctl_low_hold  <= 1'b0;
    end else begin
      data_high_q   <= data_high;
      data_low_hold <= data_low;
      ctl_high_q    <= ctl_high;
      ctl_low_hold  <= ctl_low;
    end
  end

  // Falling edge: launch the low phase captured at the preceding rising edge
  always_ff @(negedge clock) begin
    if (reset) begin
      data_low_q <= '0;
      ctl_low_q  <= 1'b0;
    end else begin
      data_low_q <= data_low_hold;
      ctl_low_q  <= ctl_low_hold;
    end
  end

  assign data_out = clock ? data_high_q : data_low_q;
  assign ctl_out  = clock ? ctl_high_q  : ctl_low_q;

endmodule

// File: rtl/rgmii_transmitter.sv
// Gigabit RGMII transmit path: frames the MAC egress byte stream with preamble
// and SFD, enforces the inter-frame gap and flags underruns with TX_ER.
module rgmii_transmitter
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [3:0]  rgmii_txd,
  output logic        rgmii_tx_ctl,
  output logic        rgmii_txc,
  output logic        busy,
  output logic [15:0] underrun_count
);

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BYTES - 1);
  localparam logic [5:0] IFG_LAST = 6'(IFG_BYTES - 1);

  tx_state_t  state;
  logic [5:0] count;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       tx_er;

  assign s_ready   = (state == DATA) || (state == DRAIN);
  assign busy      = (state != IDLE);
  assign rgmii_txc = clock;

  // Framing FSM and byte stage; the byte stage idles unless a state drives it
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 6'd0;
      tx_byte        <= IDLE_BYTE;
      tx_en          <= 1'b0;
      tx_er          <= 1'b0;
      underrun_count <= 16'd0;
    end else begin
      tx_byte <= IDLE_BYTE;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state <= PREAMBLE;
            count <= 6'd0;
          end
        end
        PREAMBLE: begin
          tx_byte <= PREAMBLE_BYTE;
          tx_en   <= 1'b1;
          if (count == PRE_LAST) begin
            state <= SFD;
            count <= 6'd0;
          end else begin
            count <= count + 6'd1;
          end
        end
        SFD: begin
          tx_byte <= SFD_BYTE;
          tx_en   <= 1'b1;
          state   <= DATA;
        end
        DATA: begin
          tx_en <= 1'b1;
          if (s_valid) begin
            tx_byte <= s_data;
            if (s_last) begin
              state <= IFG;
              count <= 6'd0;
            end
          end else begin
            // Source starved mid-frame: poison this byte and drop the rest
            tx_er          <= 1'b1;
            underrun_count <= sat_inc16(underrun_count);
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (s_valid && s_last) begin
            state <= IFG;
            count <= 6'd0;
          end
        end
        IFG: begin
          if (count == IFG_LAST) begin
            state <= IDLE;
            count <= 6'd0;
          end else begin
            count <= count + 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= 6'd0;
        end
      endcase
    end
  end

  rgmii_ddr_output_buffer #(
    .DATA_WIDTH (4)
  ) u_ddr (
    .clock     (clock),
    .reset     (reset),
    .data_high (tx_byte[3:0]),
    .data_low  (tx_byte[7:4]),
    .ctl_high  (tx_en),
    .ctl_low   (tx_en ^ tx_er),
    .data_out  (rgmii_txd),
    .ctl_out   (rgmii_tx_ctl)
  );

endmodule
